// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - host and SPI engine signal bundle for adc_scan_ctrl
interface adc_scan_ctrl_if;
    logic        en_i;
    logic        start_i;
    logic        clr_i;
    logic        strc_o;
    logic [7:0]  cmd_o;
    logic [7:0]  kmax_o;
    logic        eoc_i;
    logic [11:0] din_i;
    logic [2:0]  rd_ch_i;
    logic [11:0] rd_data_o;
    logic        done_o;
    logic        busy_o;
    logic        ovr_o;
    logic        err_o;

    // Controller side: drives the engine strobe/command and the host status
    modport master (
        input  en_i, start_i, clr_i, eoc_i, din_i, rd_ch_i,
        output strc_o, cmd_o, kmax_o, rd_data_o, done_o, busy_o, ovr_o, err_o
    );

    // Environment side: host plus SPI engine
    modport slave (
        output en_i, start_i, clr_i, eoc_i, din_i, rd_ch_i,
        input  strc_o, cmd_o, kmax_o, rd_data_o, done_o, busy_o, ovr_o, err_o
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - ADC channel scan sequencer with result bank; ADC_SCAN_AVG_EN enables 4x averaging
module adc_scan_ctrl #(
    parameter int          NCH     = 8,
    parameter logic [3:0]  CMD_LO  = 4'hC,
    parameter logic [7:0]  KMAX    = 8'd24,
    parameter logic [15:0] PERIOD  = 16'd50000,
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic           clk_i,
    input  logic           rst_i,
    adc_scan_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, STROBE, ACK, CONV, STORE} state_t;

    localparam logic [15:0] PER_LAST = PERIOD - 16'd1;
    localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;
    localparam logic [2:0]  CH_LAST  = 3'(NCH - 1);

    state_t      state, state_nxt;
    logic [2:0]  ch, ch_nxt;
    logic [15:0] tmr;
    logic [15:0] to_cnt;
    logic        expire;
    logic        to_abort;
    logic        scan_done;
    logic        bank_we;
    logic        chan_final;
    logic [11:0] store_val;
    logic [11:0] bank [0:7];

    logic        strc_r, done_r, busy_r, ovr_r, err_r;
    logic [7:0]  cmd_r;
    logic [11:0] rd_data_r;

    assign bus.strc_o    = strc_r;
    assign bus.cmd_o     = cmd_r;
    assign bus.kmax_o    = KMAX;
    assign bus.rd_data_o = rd_data_r;
    assign bus.done_o    = done_r;
    assign bus.busy_o    = busy_r;
    assign bus.ovr_o     = ovr_r;
    assign bus.err_o     = err_r;

    assign expire = bus.en_i && (tmr == PER_LAST);

`ifdef ADC_SCAN_AVG_EN
    logic [1:0]  avg_cnt;
    logic [13:0] acc;
    logic [13:0] acc_sum;

    assign acc_sum    = acc + {2'b00, bus.din_i};
    assign chan_final = (avg_cnt == 2'd3);
    assign store_val  = acc_sum[13:2];

    // Four back-to-back conversions per channel are summed; cleared between channels and scans
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            avg_cnt <= 2'd0;
            acc     <= 14'd0;
        end else if (state == IDLE || to_abort) begin
            avg_cnt <= 2'd0;
            acc     <= 14'd0;
        end else if (state == STORE) begin
            if (chan_final) begin
                avg_cnt <= 2'd0;
                acc     <= 14'd0;
            end else begin
                avg_cnt <= avg_cnt + 2'd1;
                acc     <= acc_sum;
            end
        end
    end
`else
    assign chan_final = 1'b1;
    assign store_val  = bus.din_i;
`endif

    // Next-state logic: trigger, engine handshake, timeout abort and channel stepping
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        to_abort  = 1'b0;
        scan_done = 1'b0;
        bank_we   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i || expire) begin
                    state_nxt = STROBE;
                    ch_nxt    = 3'd0;
                end
            end
            STROBE: state_nxt = ACK;
            ACK: begin
                if (!bus.eoc_i) begin
                    state_nxt = CONV;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    to_abort  = 1'b1;
                end
            end
            CONV: begin
                if (bus.eoc_i) begin
                    state_nxt = STORE;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    to_abort  = 1'b1;
                end
            end
            STORE: begin
                state_nxt = STROBE;
                if (chan_final) begin
                    bank_we = 1'b1;
                    if (ch == CH_LAST) begin
                        state_nxt = IDLE;
                        scan_done = 1'b1;
                    end else begin
                        ch_nxt = ch + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, channel and registered outputs derived from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ch     <= 3'd0;
            strc_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cmd_r  <= {1'b1, 3'd0, CMD_LO};
        end else begin
            state  <= state_nxt;
            ch     <= ch_nxt;
            strc_r <= (state_nxt == STROBE);
            busy_r <= (state_nxt != IDLE);
            done_r <= scan_done;
            if (state_nxt == STROBE && state != STROBE) begin
                cmd_r <= {1'b1, ch_nxt, CMD_LO};
            end
        end
    end

    // Handshake timeout counter restarts on every entry to ACK or CONV
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= 16'd0;
        end else if ((state_nxt == ACK && state != ACK) || (state_nxt == CONV && state != CONV)) begin
            to_cnt <= 16'd0;
        end else if (state == ACK || state == CONV) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Sample timer free-runs while enabled and wraps after PERIOD clocks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr <= 16'd0;
        end else if (!bus.en_i || tmr == PER_LAST) begin
            tmr <= 16'd0;
        end else begin
            tmr <= tmr + 16'd1;
        end
    end

    // Sticky overrun and error flags; clear wins over a same-cycle set
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_r <= 1'b0;
            err_r <= 1'b0;
        end else if (bus.clr_i) begin
            ovr_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (expire && state != IDLE) begin
                ovr_r <= 1'b1;
            end
            if (to_abort) begin
                err_r <= 1'b1;
            end
        end
    end

    // Result bank write and registered read port (read sees pre-write data)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                bank[i] <= 12'd0;
            end
            rd_data_r <= 12'd0;
        end else begin
            if (bank_we) begin
                bank[ch] <= store_val;
            end
            if ({1'b0, bus.rd_ch_i} < 4'(NCH)) begin
                rd_data_r <= bank[bus.rd_ch_i];
            end else begin
                rd_data_r <= 12'd0;
            end
        end
    end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Sequencer that sits above the SPI ADC write/read engine and drives it through a scan of `NCH` ADC channels, one conversion at a time. Each result is stored in an internal per-channel result bank. A host reads the bank through a registered read port. Scans are either triggered once by the host or repeated periodically by an internal sample timer, with overrun and engine-timeout detection.

## Interface
Parameters:
- `NCH`, 8, channels per scan, 1..8; channel index is 3 bits.
- `CMD_LO`, 4'hC, low nibble of every ADC command byte.
- `KMAX`, 8'd24, value driven on `kmax_o` (SPI clock divider for the engine).
- `PERIOD`, 16'd50000, clocks between periodic scan triggers; must be ≥ 2.
- `TIMEOUT`, 16'd4095, clocks allowed per engine handshake phase.

Ports:
- `clk_i` in 1: system clock, single clock domain.
- `rst_i` in 1: asynchronous, active-high reset.
- `en_i` in 1: periodic scan enable (level).
- `start_i` in 1: single-scan request (1-cycle pulse).
- `clr_i` in 1: clears sticky `ovr_o` and `err_o`.
- `strc_o` out 1: conversion strobe to the SPI engine.
- `cmd_o` out 8: command byte, `{1'b1, ch[2:0], CMD_LO}`.
- `kmax_o` out 8: constant `KMAX`.
- `eoc_i` in 1: engine end-of-conversion; high when idle/done.
- `din_i` in 12: engine result.
- `rd_ch_i` in 3: result bank read address.
- `rd_data_o` out 12: registered bank data.
- `done_o` out 1: 1-cycle pulse when a scan has fully completed.
- `busy_o` out 1: high from scan start to completion or abort.
- `ovr_o` out 1: sticky flag; a periodic trigger arrived while busy.
- `err_o` out 1: sticky flag; engine handshake timeout.

## Operation
- FSM states: IDLE, STROBE, ACK, CONV, STORE.
  - IDLE -> STROBE on a trigger; `ch` is set to 0.
  - STROBE: `strc_o`=1 for exactly one cycle -> ACK.
  - ACK: wait for `eoc_i`=0 (engine accepted) -> CONV.
  - CONV: wait for `eoc_i`=1 -> STORE.
  - STORE: write `din_i` into `bank[ch]`. If `ch`=NCH-1: pulse `done_o` and go to IDLE. Otherwise increment `ch` and go to STROBE.
- Trigger sources: `start_i` in IDLE, or a timer expiry in IDLE. `start_i` while busy is ignored with no flag.
- Timer: free-runs while `en_i`=1; cleared to 0 while `en_i`=0. Expires when the count reaches PERIOD-1, then wraps to 0.
  - Expiry while not IDLE sets `ovr_o`; that trigger is dropped.
  - Simultaneous `start_i` and expiry in IDLE start a single scan.
- Timeout: a 16-bit counter resets on every entry to ACK or CONV. If it reaches TIMEOUT: set `err_o`, abort to IDLE, no `done_o`. Bank entries already stored keep their values.
- `en_i` falling mid-scan: the current scan still completes.
- `clr_i` has priority over setting the flags in the same cycle. Flags are cleared only by `clr_i` or reset.
- Read port: `rd_data_o <= bank[rd_ch_i]` every cycle. Addresses ≥ NCH return 0.
  - If a STORE writes the addressed entry in the same cycle, `rd_data_o` shows the old value that cycle and the new value one cycle later.
- `cmd_o` updates on entry to STROBE and holds stable through STORE.

## Timing
- Reset values:
  - `strc_o`, `done_o`, `busy_o`, `ovr_o`, `err_o` = 0.
  - `cmd_o` = `{1'b1,3'd0,CMD_LO}`; `rd_data_o` = 0.
  - All bank entries = 0; timer = 0; FSM in IDLE.
- Reset mid-scan returns the block to the reset state immediately.
- All outputs are registered.
- Trigger to `strc_o` high: 1 cycle. `busy_o` rises in the same cycle as the first `strc_o`.
- `eoc_i` rising in CONV -> STORE next cycle. The next `strc_o` follows 1 cycle after STORE.
- `done_o` is asserted in the cycle after the last STORE. `busy_o` falls in that same cycle.
- Minimum controller overhead per channel: 3 cycles plus engine time.

## Configuration
- `ADC_SCAN_AVG_EN` defined:
  - Each channel is converted 4 times back to back: STORE loops to STROBE without incrementing `ch`.
  - Results are summed in a 14-bit accumulator and `sum[13:2]` (truncating) is written on the fourth STORE.
  - `cmd_o` stays the same across the 4 conversions; the timeout applies per conversion.
- Undefined: one conversion per channel; `din_i` is stored directly.

## Test plan
- Reset, `start_i` pulse, engine model returns 12'h100+ch for NCH=8 -> 8 `strc_o` pulses with `cmd_o` = 8'h8C, 9C, …, FC. Then `done_o` pulses once, and `rd_ch_i`=5 gives 12'h105 one cycle later.
- `en_i`=1, PERIOD=200, engine scan time 120 cycles -> one scan every 200 cycles, `ovr_o` stays 0.
- Same setup with scan time 300 -> `ovr_o`=1 after the second expiry, and each scan starts only from IDLE. `clr_i` then returns `ovr_o` to 0.
- Engine holds `eoc_i`=1 after a strobe, TIMEOUT=4095 -> `err_o`=1 and `busy_o`=0 after 4095 cycles in ACK, no `done_o`, and earlier bank entries are retained.
- Assert `rst_i` in CONV on channel 3 -> all outputs return to reset values immediately and all bank entries read 0.
- With `ADC_SCAN_AVG_EN`: samples 12'h0FF, 0FF, 100, 100 on channel 0 -> bank[0]=12'h0FF (sum 0x3FE>>2), with 4 strobes per channel, 32 strobes in total.
